// File: rtl/tick_generator.sv
// Multi-channel runtime-programmable tick-enable generator: per-channel divisor,
// periodic or one-shot mode, a blink toggle, and a free-running cycle counter.
module tick_generator #(
  parameter int unsigned  CHANNELS    = 4,
  parameter int unsigned  WIDTH       = 26,
  parameter int unsigned  DEFAULT_DIV = 25_000_000,
  localparam int unsigned CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                cfg_we,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                cfg_oneshot,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] toggle,
  output logic [CHANNELS-1:0] active,
  output logic [31:0]         free_count
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] RST_CNT = (DEFAULT_DIV == 0) ? '0 : WIDTH'(DEFAULT_DIV - 1);
  localparam logic             RST_ACT = (DEFAULT_DIV != 0);

  logic [WIDTH-1:0]    r_div [CHANNELS];
  logic [WIDTH-1:0]    r_cnt [CHANNELS];
  logic [CHANNELS-1:0] r_mode;
  logic [CHANNELS-1:0] r_active;
  logic [CHANNELS-1:0] r_tick;
  logic [CHANNELS-1:0] r_toggle;
  logic [31:0]         r_free;

  logic [WIDTH-1:0]    w_div_nxt [CHANNELS];
  logic [WIDTH-1:0]    w_cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] w_mode_nxt;
  logic [CHANNELS-1:0] w_active_nxt;
  logic [CHANNELS-1:0] w_tick_nxt;
  logic [CHANNELS-1:0] w_toggle_nxt;

  // Per-channel next state; a config write to a channel overrides its count step.
  always_comb begin
    w_div_nxt    = r_div;
    w_cnt_nxt    = r_cnt;
    w_mode_nxt   = r_mode;
    w_active_nxt = r_active;
    w_toggle_nxt = r_toggle;
    w_tick_nxt   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_we && (cfg_chan == CHAN_W'(i))) begin
        if (cfg_div != '0) begin
          w_div_nxt[i]    = cfg_div;
          w_cnt_nxt[i]    = cfg_div - WIDTH'(1);
          w_mode_nxt[i]   = cfg_oneshot;
          w_active_nxt[i] = 1'b1;
        end else begin
          w_active_nxt[i] = 1'b0;
        end
      end else if (r_active[i] && enable) begin
        if (r_cnt[i] != '0) begin
          w_cnt_nxt[i] = r_cnt[i] - WIDTH'(1);
        end else begin
          w_tick_nxt[i]   = 1'b1;
          w_toggle_nxt[i] = ~r_toggle[i];
          // One-shot parks at zero and drops active; periodic reloads.
          if (r_mode[i]) begin
            w_active_nxt[i] = 1'b0;
          end else begin
            w_cnt_nxt[i] = r_div[i] - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_div[i] <= RST_DIV;
        r_cnt[i] <= RST_CNT;
      end
      r_mode   <= '0;
      r_active <= {CHANNELS{RST_ACT}};
      r_tick   <= '0;
      r_toggle <= '0;
      r_free   <= '0;
    end else begin
      r_div    <= w_div_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mode   <= w_mode_nxt;
      r_active <= w_active_nxt;
      r_tick   <= w_tick_nxt;
      r_toggle <= w_toggle_nxt;
      r_free   <= r_free + 32'd1;
    end
  end

  assign tick       = r_tick;
  assign toggle     = r_toggle;
  assign active     = r_active;
  assign free_count = r_free;

endmodule

// File: tb/tb_tick_generator.sv
// Bench for tick_generator: directed table, multi-cycle corner sequences and
// random traffic against a phase-counting reference model (4- and 3-channel builds).
module tb_tick_generator;

  localparam int unsigned DEF = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       cfg_we;
  logic [1:0] cfg_chan;
  logic [7:0] cfg_div;
  logic       cfg_oneshot;

  logic [3:0]  tick, toggle, active;
  logic [31:0] free_count;
  logic [2:0]  tick3, toggle3, active3;
  logic [31:0] free_count3;

  always #5 clock = ~clock;

  tick_generator #(.CHANNELS(4), .WIDTH(8), .DEFAULT_DIV(DEF)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .cfg_we(cfg_we),
    .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot),
    .tick(tick), .toggle(toggle), .active(active), .free_count(free_count)
  );

  tick_generator #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DIV(DEF)) dut3 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .cfg_we(cfg_we),
    .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot),
    .tick(tick3), .toggle(toggle3), .active(active3), .free_count(free_count3)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase = enabled edges since start/last tick; tick when phase hits D.
  int          m_phase [2][4];
  int          m_div   [2][4];
  logic [3:0]  m_os  [2];
  logic [3:0]  m_act [2];
  logic [3:0]  m_tick[2];
  logic [3:0]  m_tog [2];
  int unsigned m_free;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, a, e);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_phase[k][i] = 0;
        m_div[k][i]   = int'(DEF);
      end
      m_os[k]   = '0;
      m_act[k]  = (k == 0) ? 4'hF : 4'h7;
      m_tick[k] = '0;
      m_tog[k]  = '0;
    end
    m_free = 0;
  endtask

  task automatic m_edge(input logic en, input logic we, input logic [1:0] ch,
                        input logic [7:0] d, input logic os);
    int nch;
    for (int k = 0; k < 2; k++) begin
      nch = (k == 0) ? 4 : 3;
      for (int i = 0; i < nch; i++) begin
        m_tick[k][i] = 1'b0;
        if (we && int'(ch) == i) begin
          if (d != 0) begin
            m_div[k][i]   = int'(d);
            m_os[k][i]    = os;
            m_phase[k][i] = 0;
            m_act[k][i]   = 1'b1;
          end else begin
            m_act[k][i] = 1'b0;
          end
        end else if (m_act[k][i] && en) begin
          m_phase[k][i]++;
          if (m_phase[k][i] == m_div[k][i]) begin
            m_tick[k][i]  = 1'b1;
            m_tog[k][i]   = ~m_tog[k][i];
            m_phase[k][i] = 0;
            if (m_os[k][i]) m_act[k][i] = 1'b0;
          end
        end
      end
    end
    m_free++;
  endtask

  task automatic cmp_all();
    chk("tick",     32'(tick),        32'(m_tick[0]));
    chk("toggle",   32'(toggle),      32'(m_tog[0]));
    chk("active",   32'(active),      32'(m_act[0]));
    chk("free",     free_count,       32'(m_free));
    chk("tick3",    32'(tick3),       32'(m_tick[1][2:0]));
    chk("toggle3",  32'(toggle3),     32'(m_tog[1][2:0]));
    chk("active3",  32'(active3),     32'(m_act[1][2:0]));
    chk("free3",    free_count3,      32'(m_free));
  endtask

  // Drive inputs, take one edge, advance the model, compare 1 time unit later.
  task automatic step(input logic en, input logic we, input logic [1:0] ch,
                      input logic [7:0] d, input logic os);
    enable = en; cfg_we = we; cfg_chan = ch; cfg_div = d; cfg_oneshot = os;
    @(posedge clock);
    m_edge(en, we, ch, d, os);
    #1;
    cmp_all();
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
  endtask

  typedef struct {
    logic       en;
    logic       we;
    logic [1:0] ch;
    logic [7:0] d;
    logic       os;
    logic [3:0] e_tick;
    logic [3:0] e_tog;
    logic [3:0] e_act;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int cnt;
    int at;

    // Edges 1..12 after reset release, then a D=1 periodic write to ch1 at edge 13.
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'hF};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'hF};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'hF};
    tbl[3]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'hF, 4'hF, 4'hF};
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'hF, 4'hF};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'hF, 4'hF};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'hF, 4'hF};
    tbl[7]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'hF, 4'h0, 4'hF};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'hF};
    tbl[9]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'hF};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'hF};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'hF, 4'hF, 4'hF};
    tbl[12] = '{1'b1, 1'b1, 2'd1, 8'd1, 1'b0, 4'h0, 4'hF, 4'hF};
    tbl[13] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h2, 4'hD, 4'hF};
    tbl[14] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h2, 4'hF, 4'hF};
    tbl[15] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'hF, 4'h0, 4'hF};
    tbl[16] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h2, 4'h2, 4'hF};

    reset_n = 1'b0; enable = 1'b1; cfg_we = 1'b0; cfg_chan = '0; cfg_div = '0; cfg_oneshot = 1'b0;
    m_reset();
    #23;
    chk("rst_tick",   32'(tick),   32'h0);
    chk("rst_toggle", 32'(toggle), 32'h0);
    chk("rst_active", 32'(active), 32'hF);
    chk("rst_free",   free_count,  32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].en, tbl[i].we, tbl[i].ch, tbl[i].d, tbl[i].os);
      chk("tbl_tick",   32'(tick),   32'(tbl[i].e_tick));
      chk("tbl_toggle", 32'(toggle), 32'(tbl[i].e_tog));
      chk("tbl_active", 32'(active), 32'(tbl[i].e_act));
      chk("tbl_free",   free_count,  32'(i + 1));
    end

    // One-shot D=5 on ch2: a single pulse at E0+5, then silence.
    step(1'b1, 1'b1, 2'd2, 8'd5, 1'b1);
    cnt = 0; at = 0;
    for (int j = 1; j <= 25; j++) begin
      idle();
      if (tick[2]) begin cnt++; at = j; end
    end
    chk("os_count",  32'(cnt), 32'd1);
    chk("os_at",     32'(at),  32'd5);
    chk("os_active", 32'(active[2]), 32'd0);

    // Ch0 D=4 with a 3-cycle enable drop mid-count: tick moves from E0+4 to E0+7.
    step(1'b1, 1'b1, 2'd0, 8'd4, 1'b0);
    idle();
    idle();
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    at = 0;
    for (int j = 1; j <= 10; j++) begin
      idle();
      if (tick[0] && at == 0) at = j;
    end
    chk("pause_at", 32'(at), 32'd2);

    // Ch3 D=4, rewritten to D=6 on its terminal-count edge.
    step(1'b1, 1'b1, 2'd3, 8'd4, 1'b0);
    for (int j = 0; j < 3; j++) idle();
    step(1'b1, 1'b1, 2'd3, 8'd6, 1'b0);
    chk("tc_suppress", 32'(tick[3]), 32'd0);
    at = 0;
    for (int j = 1; j <= 10; j++) begin
      idle();
      if (tick[3] && at == 0) at = j;
    end
    chk("tc_restart_at", 32'(at), 32'd6);

    // Channel index 3 is out of range for the 3-channel build.
    step(1'b1, 1'b1, 2'd3, 8'd2, 1'b1);
    for (int j = 0; j < 4; j++) idle();

    // D=0 disables ch3.
    step(1'b1, 1'b1, 2'd3, 8'd0, 1'b0);
    chk("dis_active", 32'(active[3]), 32'd0);
    cnt = 0;
    for (int j = 0; j < 12; j++) begin
      idle();
      if (tick[3]) cnt++;
    end
    chk("dis_ticks", 32'(cnt), 32'd0);

    // Random traffic against the model.
    for (int j = 0; j < 400; j++) begin
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 7) == 0),
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    // Restart ch0 periodically so ticks are running, then reset between edges.
    step(1'b1, 1'b1, 2'd0, 8'd1, 1'b0);
    idle();
    idle();
    #2;
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("mid_rst_tick",   32'(tick),   32'h0);
    chk("mid_rst_toggle", 32'(toggle), 32'h0);
    chk("mid_rst_free",   free_count,  32'h0);
    chk("mid_rst_active", 32'(active), 32'hF);
    chk("mid_rst_free3",  free_count3, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    at = 0;
    for (int j = 1; j <= 8; j++) begin
      idle();
      if (tick[0] && at == 0) at = j;
    end
    chk("post_rst_first", 32'(at), 32'(DEF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
